alu_cmd_sequencer: RTL

- Upstream command stage for the iterative 4-mode ALU (MUL, DIV, SHIFT, AVG).
- Buffers producer commands in a small FIFO and issues them one at a time using the ALU's single-cycle valid pulse.
- Waits for the ALU ready, captures the 64-bit out, and returns it with tag and mode over a valid/ready response channel.
- A watchdog bounds the wait when the ALU never signals ready.

---
 rtl/alu_pkg.sv | 19 +
 rtl/cmd_fifo.sv | 53 +++++
 rtl/alu_cmd_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings and limits for the ALU command sequencer
package alu_pkg;

    localparam logic [1:0] MODE_MUL   = 2'd0;
    localparam logic [1:0] MODE_DIV   = 2'd1;
    localparam logic [1:0] MODE_SHIFT = 2'd2;
    localparam logic [1:0] MODE_AVG   = 2'd3;

    localparam int ALU_LATENCY_MAX = 32;
    localparam int TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO buffering producer commands ahead of the ALU
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 72
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign rdata_o = mem_q[rd_q];
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;

    // next pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage needs no reset: entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues commands and issues them one at a time to the iterative ALU
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_valid,
    output logic [1:0]       alu_mode,
    output logic [31:0]      alu_in_A,
    output logic [31:0]      alu_in_B,
    input  logic             alu_ready,
    input  logic [63:0]      alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [1:0]       rsp_mode,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout
);
    localparam int W  = 2 + 64 + TAG_W;
    localparam int CW = $clog2(TIMEOUT);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_mode_q;
    logic [31:0]      op_a_q, op_b_q;
    logic [TAG_W-1:0] op_tag_q;
    logic             full, empty, pop;
    logic [W-1:0]     head;

    assign cmd_ready = !full;
    assign pop       = state_q == S_IDLE && !empty;

    cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .wdata_i ({cmd_mode, cmd_a, cmd_b, cmd_tag}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // issue/wait/respond sequencer; every ALU and response output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_mode_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_tag_q    <= '0;
            alu_valid   <= 1'b0;
            alu_mode    <= '0;
            alu_in_A    <= '0;
            alu_in_B    <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_mode    <= '0;
            rsp_tag     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        {op_mode_q, op_a_q, op_b_q, op_tag_q} <= head;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_valid <= 1'b1;
                    alu_mode  <= op_mode_q;
                    alu_in_A  <= op_a_q;
                    alu_in_B  <= op_b_q;
                    cnt_q     <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    alu_valid <= 1'b0;
                    alu_mode  <= '0;
                    alu_in_A  <= '0;
                    alu_in_B  <= '0;
                    if (alu_ready || cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_valid   <= 1'b1;
                        rsp_data    <= alu_ready ? alu_out : 64'd0;
                        rsp_timeout <= !alu_ready;
                        rsp_mode    <= op_mode_q;
                        rsp_tag     <= op_tag_q;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
